// File: rtl/text_scanout_pkg.sv
// Shared definitions for the text-mode scanout: cell word layout, bus widths, FSM encoding.
package text_scanout_pkg;

  localparam int RA_W   = 13;
  localparam int FA_W   = 11;
  localparam int CELL_W = 18;

  localparam int BL_HI = 17, BL_LO = 16;
  localparam int BG_HI = 15, BG_LO = 12;
  localparam int FG_HI = 11, FG_LO = 8;
  localparam int CH_HI = 7,  CH_LO = 0;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREFETCH = 3'd1,
    ST_READY    = 3'd2,
    ST_ACTIVE   = 3'd3,
    ST_BLANK    = 3'd4
  } state_e;

  // Field order matches the cell word above the character byte.
  typedef struct packed {
    logic [1:0] bl;
    logic [3:0] bg;
    logic [3:0] fg;
  } attr_t;

  function automatic attr_t cell_attr(input logic [CELL_W-1:0] w);
    return attr_t'(w[BL_HI:FG_LO]);
  endfunction

  function automatic logic [7:0] cell_char(input logic [CELL_W-1:0] w);
    return w[CH_HI:CH_LO];
  endfunction

endpackage

// File: rtl/text_pixel_shifter.sv
// Glyph-row shifter for one 8-pixel cell plus its attribute register and colour select.
module text_pixel_shifter
  import text_scanout_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic       shift_i,
  input  logic       blink_i,
  input  logic [7:0] glyph_i,
  input  attr_t      attr_i,
  output logic [3:0] pix_o
);

  logic [7:0] sh_q;
  attr_t      attr_q;
  logic [3:0] fg, bg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sh_q   <= '0;
      attr_q <= '0;
    end else if (load_i) begin
      sh_q   <= glyph_i;
      attr_q <= attr_i;
    end else if (shift_i) begin
      sh_q   <= {sh_q[6:0], 1'b0};
    end
  end

  // Reverse video first, so a blinking reversed cell blanks to its swapped background.
  always_comb begin
    fg = attr_q.bl[1] ? attr_q.bg : attr_q.fg;
    bg = attr_q.bl[1] ? attr_q.fg : attr_q.bg;
    if (attr_q.bl[0] && blink_i) pix_o = bg;
    else                         pix_o = sh_q[7] ? fg : bg;
  end

endmodule

// File: rtl/text_scanout.sv
// Text-mode scanout: cell RAM -> font ROM -> pixel shifter. Define TEXT_SCANOUT_BLINK_EN
// to add the frame counter that drives blinking cells (BL[0]).
module text_scanout
  import text_scanout_pkg::*;
#(
  parameter int COLS   = 120,
  parameter int ROWS   = 61,
  parameter int CELL_H = 8
) (
  input  logic              clk50,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              line_start,
  input  logic              de,
  output logic [RA_W-1:0]   RAddr,
  input  logic [CELL_W-1:0] RData,
  output logic [FA_W-1:0]   FAddr,
  input  logic [7:0]        FData,
  output logic [3:0]        pix_color,
  output logic              pix_valid,
  output logic              underrun
);

  localparam int CW = $clog2(COLS + 1);
  localparam int RW = $clog2(ROWS + 1);
  localparam int GW = ($clog2(CELL_H) > 3) ? $clog2(CELL_H) : 3;

  state_e          state_q, state_d;
  logic [2:0]      vld_pipe_q;
  logic [RA_W-1:0] raddr_q, row_base_q;
  logic [CW-1:0]   col_q;
  logic [2:0]      px_q;
  logic [RW-1:0]   row_q;
  logic [GW-1:0]   gline_q;
  attr_t           nattr_q;
  logic [7:0]      nglyph_q, ld_glyph;
  logic [3:0]      pix_q, sh_pix;
  logic            pv_q, under_q, blink;
  logic            ls_acc, go, shift, last_px, line_end, row_end, frame_end, issue, load;

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (frame_start)  state_d = ST_IDLE;
    else if (ls_acc)  state_d = ST_PREFETCH;
    else begin
      case (state_q)
        ST_PREFETCH: if (vld_pipe_q[2]) state_d = ST_READY;
        ST_READY:    if (de)            state_d = ST_ACTIVE;
        ST_ACTIVE:   if (line_end)      state_d = frame_end ? ST_BLANK : ST_IDLE;
        default:     state_d = state_q;
      endcase
    end
  end

  // vld_pipe_q: [0] address on RAddr, [1] RData valid, [2] FData valid.
  always_comb begin
    ls_acc    = line_start && !frame_start && (state_q != ST_BLANK);
    go        = !frame_start && !ls_acc;
    shift     = de && (state_q == ST_READY || state_q == ST_ACTIVE);
    last_px   = shift && (px_q == 3'd7);
    line_end  = go && last_px && (col_q == CW'(COLS - 1));
    row_end   = (gline_q == GW'(CELL_H - 1));
    frame_end = row_end && (row_q == RW'(ROWS - 1));
    issue     = !frame_start &&
                (ls_acc || (shift && px_q == 3'd0 && col_q != CW'(COLS - 1)));
    load      = go && ((state_q == ST_PREFETCH && vld_pipe_q[2]) || (last_px && !line_end));
    ld_glyph  = (state_q == ST_PREFETCH) ? FData : nglyph_q;
  end

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      raddr_q    <= '0;
      row_base_q <= '0;
      col_q      <= '0;
      px_q       <= '0;
      row_q      <= '0;
      gline_q    <= '0;
      nattr_q    <= '0;
      nglyph_q   <= '0;
      pix_q      <= '0;
      pv_q       <= 1'b0;
      under_q    <= 1'b0;
    end else begin
      vld_pipe_q <= go ? {vld_pipe_q[1:0], issue} : {2'b00, issue};
      if (issue)         raddr_q  <= ls_acc ? row_base_q : raddr_q + RA_W'(1);
      if (vld_pipe_q[1]) nattr_q  <= cell_attr(RData);
      if (vld_pipe_q[2]) nglyph_q <= FData;
      if (ls_acc) begin
        px_q  <= '0;
        col_q <= '0;
      end else if (shift) begin
        px_q <= px_q + 3'd1;
        if (last_px) col_q <= col_q + CW'(1);
      end
      // Row base steps by COLS so the cell address never needs a multiply.
      if (frame_start) begin
        row_q      <= '0;
        gline_q    <= '0;
        row_base_q <= '0;
      end else if (line_end) begin
        if (row_end) begin
          gline_q    <= '0;
          row_q      <= row_q + RW'(1);
          row_base_q <= row_base_q + RA_W'(COLS);
        end else begin
          gline_q <= gline_q + GW'(1);
        end
      end
      pix_q <= shift ? sh_pix : 4'h0;
      pv_q  <= de;
      if (de && !(state_q inside {ST_READY, ST_ACTIVE, ST_BLANK})) under_q <= 1'b1;
    end
  end

`ifdef TEXT_SCANOUT_BLINK_EN
  logic [7:0] fcnt_q;
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n)           fcnt_q <= '0;
    else if (frame_start) fcnt_q <= fcnt_q + 8'd1;
  end
  assign blink = fcnt_q[5];
`else
  assign blink = 1'b0;
`endif

  text_pixel_shifter u_shift (
    .clk_i   (clk50),
    .rst_ni  (rst_n),
    .load_i  (load),
    .shift_i (shift),
    .blink_i (blink),
    .glyph_i (ld_glyph),
    .attr_i  (nattr_q),
    .pix_o   (sh_pix)
  );

  assign RAddr     = raddr_q;
  assign FAddr     = vld_pipe_q[1] ? {cell_char(RData), gline_q[2:0]} : '0;
  assign pix_color = pix_q;
  assign pix_valid = pv_q;
  assign underrun  = under_q;

endmodule
